ordering_stream_bridge: RTL and testbench

- Parametrised successor to the fixed 8x8-bit ordering register path. Moves city orderings between a host beat interface and the replica ordering shift chain.
- Configurable beat width, element width, replica count and city count.
- Modes: write, destructive read, and non-destructive rotate-read. Rotate-read re-injects every element read back into the chain.
- Sits between the host/DMA side and ordering chain stage 0 (input) and stage replica_num (output).

---
 rtl/ordering_stream_bridge_if.sv | 54 +++++
 rtl/ordering_stream_bridge.sv | 197 +++++++++++++++++++
 tb/tb_ordering_stream_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ordering_stream_bridge_if.sv
// Host command/beat handshakes and the chain-side element port
// of the ordering stream bridge.
interface ordering_stream_bridge_if #(
  parameter int elem_w     = 8,
  parameter int beat_elems = 8
) ();
  localparam int beat_w = beat_elems * elem_w;

  logic              cmd_start;
  logic [1:0]        cmd_mode;
  logic              busy;
  logic              done;
  logic              wr_valid;
  logic              wr_ready;
  logic [beat_w-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [beat_w-1:0] rd_data;
  logic              chain_shift;
  logic [elem_w-1:0] chain_in_data;
  logic [elem_w-1:0] chain_out_data;

  modport master (
    output cmd_start,
    output cmd_mode,
    output wr_valid,
    output wr_data,
    output rd_ready,
    output chain_out_data,
    input  busy,
    input  done,
    input  wr_ready,
    input  rd_valid,
    input  rd_data,
    input  chain_shift,
    input  chain_in_data
  );

  modport slave (
    input  cmd_start,
    input  cmd_mode,
    input  wr_valid,
    input  wr_data,
    input  rd_ready,
    input  chain_out_data,
    output busy,
    output done,
    output wr_ready,
    output rd_valid,
    output rd_data,
    output chain_shift,
    output chain_in_data
  );
endinterface

// File: rtl/ordering_stream_bridge.sv
// Moves city orderings between host beats and the replica
// ordering shift chain: write, destructive read, rotate-read.
module ordering_stream_bridge #(
  parameter int replica_num = 32,
  parameter int city_num    = 64,
  parameter int elem_w      = 8,
  parameter int beat_elems  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  ordering_stream_bridge_if.slave bus
);
  localparam int total = replica_num * city_num;
  localparam int cnt_w = $clog2(total + 1);
  localparam int idx_w =
    (beat_elems > 1) ? $clog2(beat_elems) : 1;

  localparam logic [cnt_w-1:0] last_elem =
    cnt_w'(total - 1);
  localparam logic [idx_w-1:0] last_idx =
    idx_w'(beat_elems - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    FLUSH
  } state_t;

  typedef logic [beat_elems-1:0][elem_w-1:0] beat_t;

  state_t           state_q;
  state_t           state_d;
  logic             done_q;
  logic             done_d;
  logic [cnt_w-1:0] ecnt_q;
  logic             wb_q;

  beat_t            wbuf_q;
  logic [idx_w-1:0] widx_q;
  logic             wfull_q;

  beat_t            pbuf_q;
  logic [idx_w-1:0] pidx_q;
  logic             pfull_q;

  beat_t            rdata_q;
  logic             rvalid_q;

  logic              mode_wr;
  logic              mode_rd;
  logic              start_ok;
  logic              wr_hs;
  logic              rd_hs;
  logic              pmove;
  logic              shift;
  logic              wr_ready_c;
  logic [elem_w-1:0] chain_in_c;

  assign mode_wr  = (bus.cmd_mode == 2'd0);
  assign mode_rd  = (bus.cmd_mode == 2'd1)
                  | (bus.cmd_mode == 2'd2);
  assign start_ok = (state_q == IDLE) & bus.cmd_start;

  assign wr_hs = bus.wr_valid & wr_ready_c;
  assign rd_hs = rvalid_q & bus.rd_ready;

  // a full packer hands over when the output slot frees up
  assign pmove = pfull_q & (~rvalid_q | bus.rd_ready);

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    shift      = 1'b0;
    wr_ready_c = 1'b0;
    chain_in_c = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_start) begin
          unique case (1'b1)
            mode_wr: state_d = WRITE;
            mode_rd: state_d = READ;
            default: state_d = IDLE;
          endcase
        end
      end
      WRITE: begin
        wr_ready_c = ~wfull_q;
        shift      = wfull_q;
        if (wfull_q) begin
          chain_in_c = wbuf_q[widx_q];
        end
        if (shift && ecnt_q == last_elem) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      READ: begin
        shift = ~pfull_q;
        if (wb_q) begin
          chain_in_c = bus.chain_out_data;
        end
        if (shift && ecnt_q == last_elem) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!pfull_q && rd_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecnt_q <= '0;
      wb_q   <= 1'b0;
    end else if (start_ok) begin
      ecnt_q <= '0;
      wb_q   <= (bus.cmd_mode == 2'd2);
    end else if (shift) begin
      ecnt_q <= ecnt_q + cnt_w'(1);
    end
  end

  // unpack: one beat drains an element per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbuf_q  <= '0;
      widx_q  <= '0;
      wfull_q <= 1'b0;
    end else if (wr_hs) begin
      wbuf_q  <= bus.wr_data;
      widx_q  <= '0;
      wfull_q <= 1'b1;
    end else if (state_q == WRITE && wfull_q) begin
      if (widx_q == last_idx) begin
        widx_q  <= '0;
        wfull_q <= 1'b0;
      end else begin
        widx_q <= widx_q + idx_w'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pbuf_q  <= '0;
      pidx_q  <= '0;
      pfull_q <= 1'b0;
    end else if (state_q == READ && !pfull_q) begin
      pbuf_q[pidx_q] <= bus.chain_out_data;
      if (pidx_q == last_idx) begin
        pidx_q  <= '0;
        pfull_q <= 1'b1;
      end else begin
        pidx_q <= pidx_q + idx_w'(1);
      end
    end else if (pmove) begin
      pidx_q  <= '0;
      pfull_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (pmove) begin
      rdata_q  <= pbuf_q;
      rvalid_q <= 1'b1;
    end else if (rd_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.wr_ready      = wr_ready_c;
  assign bus.rd_valid      = rvalid_q;
  assign bus.rd_data       = rdata_q;
  assign bus.chain_shift   = shift;
  assign bus.chain_in_data = chain_in_c;
endmodule

// File: tb/tb_ordering_stream_bridge.sv
// Bench for ordering_stream_bridge: shift-chain model, queue
// reference for beats/elements, random handshakes.
module tb_ordering_stream_bridge;
  localparam int RN = 2;
  localparam int CN = 8;
  localparam int EW = 8;
  localparam int BE = 4;
  localparam int TOTAL = RN * CN;
  localparam int BW = BE * EW;

  localparam int M_IDLE = 0;
  localparam int M_WR   = 1;
  localparam int M_RD   = 2;
  localparam int M_ROT  = 3;

  logic clk = 1'b0;
  logic reset;
  logic chain_clr;

  int n_chk = 0;
  int n_fail = 0;
  int mode_exp = M_IDLE;
  int shifts;
  int busy_cycles;
  int done_cnt;
  int beats_seen;

  logic [BW-1:0] first_beat;
  logic [BW-1:0] prev_data;
  logic          prev_hold;

  logic [EW-1:0] chain [TOTAL];
  logic [EW-1:0] snap [TOTAL];
  logic [EW-1:0] exp_in [$];
  logic [BW-1:0] exp_rd [$];
  logic [BW-1:0] wr_beats [$];

  always #5 clk = ~clk;

  ordering_stream_bridge_if #(
    .elem_w(EW), .beat_elems(BE)
  ) bus ();

  ordering_stream_bridge #(
    .replica_num(RN), .city_num(CN),
    .elem_w(EW), .beat_elems(BE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // replica chain: stage 0 is chain[0], output is the last stage
  always @(posedge clk) begin
    if (chain_clr) begin
      for (int i = 0; i < TOTAL; i++) chain[i] <= '0;
    end else if (bus.chain_shift) begin
      for (int i = TOTAL - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= bus.chain_in_data;
    end
  end
  assign bus.chain_out_data = chain[TOTAL-1];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_cnt++;
        chk("done_busy_low", bus.busy, 0);
      end
      if (prev_hold) begin
        chk("rd_hold_valid", bus.rd_valid, 1);
        chk("rd_hold_data", bus.rd_data, prev_data);
      end
      prev_hold = bus.rd_valid && !bus.rd_ready;
      prev_data = bus.rd_data;
      if (mode_exp == M_IDLE) begin
        chk("idle_shift", bus.chain_shift, 0);
      end else if (mode_exp == M_WR) begin
        if (bus.chain_shift) begin
          shifts++;
          if (exp_in.size() == 0) chk("wr_extra_shift", 1, 0);
          else chk("wr_elem", bus.chain_in_data, exp_in.pop_front());
        end
      end else begin
        if (bus.chain_shift) begin
          shifts++;
          if (shifts > TOTAL) chk("rd_extra_shift", shifts, TOTAL);
          chk("rd_chain_in", bus.chain_in_data,
              (mode_exp == M_ROT) ? bus.chain_out_data : '0);
        end
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_rd.size() == 0) begin
            chk("rd_extra_beat", 1, 0);
          end else begin
            if (beats_seen == 0) first_beat = bus.rd_data;
            beats_seen++;
            chk("rd_beat", bus.rd_data, exp_rd.pop_front());
          end
        end
      end
    end
  end

  task automatic clear_counts();
    shifts = 0;
    busy_cycles = 0;
    done_cnt = 0;
    beats_seen = 0;
  endtask

  task automatic start_cmd(input logic [1:0] m, input int mexp);
    @(posedge clk); #1;
    mode_exp = mexp;
    bus.cmd_start = 1'b1;
    bus.cmd_mode = m;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (!bus.done && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.done) chk(name, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_write(input int gap);
    bit got;
    int g;
    exp_in.delete();
    foreach (wr_beats[b])
      for (int e = 0; e < BE; e++)
        exp_in.push_back(wr_beats[b][e*EW +: EW]);
    clear_counts();
    start_cmd(2'd0, M_WR);
    foreach (wr_beats[b]) begin
      got = 1'b0;
      g = 0;
      while (!got && g < 100) begin
        bus.wr_data = wr_beats[b];
        bus.wr_valid = ($urandom_range(99) >= gap);
        got = bus.wr_valid && bus.wr_ready;
        @(posedge clk); #1;
        g++;
      end
      if (!got) chk("wr_accept_timeout", 0, 1);
    end
    bus.wr_valid = 1'b0;
    wait_done("wr_done_timeout");
    mode_exp = M_IDLE;
    chk("wr_shifts", shifts, TOTAL);
    chk("wr_left", exp_in.size(), 0);
    chk("wr_done_cnt", done_cnt, 1);
  endtask

  task automatic load_read_model();
    logic [BW-1:0] b;
    exp_rd.delete();
    for (int i = 0; i < TOTAL; i++) snap[i] = chain[i];
    for (int k = 0; k < TOTAL / BE; k++) begin
      b = '0;
      for (int e = 0; e < BE; e++)
        b[e*EW +: EW] = chain[TOTAL-1-(k*BE+e)];
      exp_rd.push_back(b);
    end
  endtask

  task automatic run_read(input logic [1:0] m, input int busy_pct,
                          input bit inject, input bit stall);
    int g;
    int bad;
    load_read_model();
    clear_counts();
    bus.rd_ready = !stall;
    start_cmd(m, (m == 2'd2) ? M_ROT : M_RD);
    if (stall) begin
      g = 0;
      while (!bus.rd_valid && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
      repeat (10) begin
        @(posedge clk); #1;
      end
      chk("stall_shifts", shifts, 8);
      chk("stall_rd_data", bus.rd_data, 32'h03020100);
    end
    g = 0;
    while (!bus.done && g < 400) begin
      bus.rd_ready = ($urandom_range(99) >= busy_pct);
      bus.cmd_start = inject && (g == 5);
      bus.cmd_mode = 2'd0;
      @(posedge clk); #1;
      g++;
    end
    bus.cmd_start = 1'b0;
    bus.rd_ready = 1'b0;
    if (!bus.done) chk("rd_done_timeout", 0, 1);
    @(posedge clk); #1;
    mode_exp = M_IDLE;
    chk("rd_shifts", shifts, TOTAL);
    chk("rd_left", exp_rd.size(), 0);
    chk("rd_done_cnt", done_cnt, 1);
    bad = 0;
    for (int i = 0; i < TOTAL; i++)
      if (chain[i] !== ((m == 2'd2) ? snap[i] : '0)) bad++;
    chk("chain_after", bad, 0);
  endtask

  task automatic run_ignored();
    clear_counts();
    start_cmd(2'd3, M_IDLE);
    chk("m3_busy_now", bus.busy, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("m3_busy", bus.busy, 0);
    chk("m3_done", done_cnt, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_wr_ready"}, bus.wr_ready, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_chain_shift"}, bus.chain_shift, 0);
    chk({tag, "_chain_in"}, bus.chain_in_data, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int r;
    bus.cmd_start = 1'b0;
    bus.cmd_mode = 2'd0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.rd_ready = 1'b0;
    reset = 1'b1;
    chain_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    chain_clr = 1'b0;

    run_ignored();

    wr_beats = '{32'h03020100, 32'h07060504,
                 32'h0B0A0908, 32'h0F0E0D0C};
    run_write(0);
    chk("wr_busy_cycles", busy_cycles, 20);

    run_read(2'd2, 0, 1'b1, 1'b0);
    chk("rot_first_beat", first_beat, 32'h03020100);
    chk("rot_beats", beats_seen, 4);

    run_read(2'd1, 0, 1'b0, 1'b1);

    clear_counts();
    exp_in.delete();
    repeat (TOTAL / BE)
      for (int e = 0; e < BE; e++) exp_in.push_back(8'(8'hA0 + e));
    start_cmd(2'd0, M_WR);
    bus.wr_data = 32'hA3A2A1A0;
    bus.wr_valid = 1'b1;
    g = 0;
    while (shifts < 6 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("rst_pre_shifts", shifts, 6);
    #2;
    reset = 1'b1;
    mode_exp = M_IDLE;
    #1;
    chk_all_zero("async_rst");
    bus.wr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    run_write(30);
    run_read(2'd2, 40, 1'b0, 1'b0);
    chk("post_rst_first", first_beat, 32'h03020100);

    for (int it = 0; it < 10; it++) begin
      r = $urandom_range(3);
      if (r == 0) begin
        wr_beats.delete();
        repeat (TOTAL / BE) wr_beats.push_back($urandom);
        run_write($urandom_range(60));
      end else if (r == 3) begin
        run_ignored();
      end else begin
        run_read((r == 1) ? 2'd1 : 2'd2, $urandom_range(70),
                 1'($urandom_range(1)), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
